// File: rtl/lab_nios2_qsys_0_oci_dct_sequencer.sv
// lab_nios2_qsys_0_oci_dct_sequencer: packs 2-bit trace codes into 30-bit frames and sequences end-of-test draining
module lab_nios2_qsys_0_oci_dct_sequencer #(
    parameter int FRAME_CODES = 15,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trc_enable,
    input  logic                   dct_valid,
    input  logic [1:0]             dct_code,
    output logic                   dct_ready,
    input  logic                   flush_req,
    input  logic                   test_ending,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [35:0]            out_data,
    output logic [29:0]            dct_buffer,
    output logic [3:0]             dct_count,
    output logic                   test_has_ended,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]  state;
    logic        flush_pending;
    logic        full, ofree, xfer, acc, te_set;
    logic [3:0]  cnt_base, cnt_n;
    logic [29:0] buf_base, buf_n;
    assign full      = dct_count == 4'(FRAME_CODES);
    assign ofree     = !out_valid || out_ready;
    assign xfer      = ofree && (full || (flush_pending && dct_count != 4'd0));
    // a full buffer may still accept when its frame leaves in the same cycle
    assign dct_ready = trc_enable && state == RUN && (!full || xfer);
    assign acc       = dct_valid && dct_ready;
    assign te_set    = state == RUN && test_ending;
    assign cnt_base  = xfer ? 4'd0 : dct_count;
    assign buf_base  = xfer ? 30'd0 : dct_buffer;
    assign cnt_n     = cnt_base + 4'(acc);
    assign buf_n     = acc ? {buf_base[27:0], dct_code} : buf_base;
    assign test_has_ended = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            flush_pending <= 1'b0;
            dct_buffer    <= '0;
            dct_count     <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            stall_count   <= '0;
        end else begin
            dct_buffer <= buf_n;
            dct_count  <= cnt_n;
            out_valid  <= xfer || (out_valid && !out_ready);
            if (xfer)
                out_data <= {full ? 2'b10 : 2'b01, dct_count, dct_buffer};
            // a pending flush on an empty buffer would never complete, so it is never kept
            flush_pending <= cnt_n != 4'd0 &&
                (te_set || (!xfer && (flush_pending || (flush_req && state != DONE))));
            if (state == RUN && trc_enable && dct_valid && !dct_ready && stall_count != '1)
                stall_count <= stall_count + STALL_CNT_W'(1);
            if (te_set)
                state <= DRAIN;
            else if (state == DRAIN && dct_count == 4'd0 && !flush_pending && ofree)
                state <= DONE;
        end
    end
endmodule

// File: tb/tb_lab_nios2_qsys_0_oci_dct_sequencer.sv
// tb_lab_nios2_qsys_0_oci_dct_sequencer: directed checks of frame packing, flush, backpressure, drain and reset
module tb_lab_nios2_qsys_0_oci_dct_sequencer;
    logic        clk = 0, reset = 1, trc_enable = 0, dct_valid = 0;
    logic        flush_req = 0, test_ending = 0, out_ready = 0;
    logic [1:0]  dct_code = 0;
    logic        dct_ready, out_valid, test_has_ended;
    logic [35:0] out_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  stall_count;
    int tests = 0, fails = 0;
    logic [1:0] codes3 [3] = '{2'd3, 2'd2, 2'd1};
    logic [1:0] codes7 [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    lab_nios2_qsys_0_oci_dct_sequencer dut (
        .clk(clk), .reset(reset), .trc_enable(trc_enable), .dct_valid(dct_valid),
        .dct_code(dct_code), .dct_ready(dct_ready), .flush_req(flush_req),
        .test_ending(test_ending), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_has_ended(test_has_ended), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        tick; tick;
        reset = 0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        tests++; if (out_data !== 36'h0) begin fails++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        tests++; if (dct_buffer !== 30'h0) begin fails++; $display("FAIL reset_buffer got %0h exp 0", dct_buffer); end
        tests++; if (dct_count !== 4'h0) begin fails++; $display("FAIL reset_count got %0h exp 0", dct_count); end
        tests++; if (test_has_ended !== 1'b0) begin fails++; $display("FAIL reset_ended got %0h exp 0", test_has_ended); end
        tests++; if (stall_count !== 8'h0) begin fails++; $display("FAIL reset_stall got %0h exp 0", stall_count); end
        tests++; if (dct_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_disabled got %0h exp 0", dct_ready); end
        trc_enable = 1;
        #1;
        tests++; if (dct_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_run got %0h exp 1", dct_ready); end
    endtask

    task automatic test_full_frame;
        out_ready = 1;
        for (int i = 0; i < 15; i++) begin
            dct_valid = 1; dct_code = 2'b01;
            tick;
        end
        dct_valid = 0;
        tests++; if (dct_count !== 4'd15) begin fails++; $display("FAIL full_count got %0h exp f", dct_count); end
        tests++; if (dct_buffer !== 30'h15555555) begin fails++; $display("FAIL full_buffer got %0h exp 15555555", dct_buffer); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid got %0h exp 0", out_valid); end
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'hBD5555555) begin fails++; $display("FAIL full_data got %0h exp bd5555555", out_data); end
        tests++; if (dct_count !== 4'd0) begin fails++; $display("FAIL full_count_clear got %0h exp 0", dct_count); end
        tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_one_cycle got %0h exp 0", out_valid); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            dct_valid = 1; dct_code = codes3[i];
            tick;
        end
        dct_valid = 0; flush_req = 1;
        tick;
        flush_req = 0;
        tests++; if (dct_count !== 4'd3) begin fails++; $display("FAIL flush_count got %0h exp 3", dct_count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_early_valid got %0h exp 0", out_valid); end
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'h4C0000039) begin fails++; $display("FAIL flush_data got %0h exp 4c0000039", out_data); end
        tests++; if (dct_count !== 4'd0) begin fails++; $display("FAIL flush_count_clear got %0h exp 0", dct_count); end
        tick;
        flush_req = 1;
        tick;
        flush_req = 0;
        tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_flush_a got %0h exp 0", out_valid); end
        tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_flush_b got %0h exp 0", out_valid); end
        dct_valid = 1; dct_code = 2'd2;
        tick;
        trc_enable = 0;
        #1;
        tests++; if (dct_ready !== 1'b0) begin fails++; $display("FAIL disabled_ready got %0h exp 0", dct_ready); end
        tick; tick;
        tests++; if (dct_count !== 4'd1) begin fails++; $display("FAIL disabled_count got %0h exp 1", dct_count); end
        tests++; if (dct_buffer !== 30'h2) begin fails++; $display("FAIL disabled_buffer got %0h exp 2", dct_buffer); end
        dct_valid = 0; flush_req = 1;
        tick;
        flush_req = 0;
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL disabled_flush_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'h440000002) begin fails++; $display("FAIL disabled_flush_data got %0h exp 440000002", out_data); end
        trc_enable = 1;
        tick;
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        tests++; if (stall_count !== 8'd0) begin fails++; $display("FAIL bp_stall_start got %0h exp 0", stall_count); end
        for (int i = 0; i < 30; i++) begin
            dct_valid = 1; dct_code = (i < 15) ? 2'd2 : 2'd3;
            #1;
            tests++; if (dct_ready !== 1'b1) begin fails++; $display("FAIL bp_fill_ready_%0d got %0h exp 1", i, dct_ready); end
            tick;
        end
        #1;
        tests++; if (dct_ready !== 1'b0) begin fails++; $display("FAIL bp_stalled_ready got %0h exp 0", dct_ready); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_held_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'hBEAAAAAAA) begin fails++; $display("FAIL bp_first_data got %0h exp beaaaaaaa", out_data); end
        tests++; if (dct_count !== 4'd15) begin fails++; $display("FAIL bp_count got %0h exp f", dct_count); end
        tests++; if (dct_buffer !== 30'h3FFFFFFF) begin fails++; $display("FAIL bp_buffer got %0h exp 3fffffff", dct_buffer); end
        repeat (5) tick;
        tests++; if (stall_count !== 8'd5) begin fails++; $display("FAIL bp_stall got %0h exp 5", stall_count); end
        tests++; if (out_data !== 36'hBEAAAAAAA) begin fails++; $display("FAIL bp_data_hold got %0h exp beaaaaaaa", out_data); end
        dct_valid = 0; out_ready = 1;
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_second_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'hBFFFFFFFF) begin fails++; $display("FAIL bp_second_data got %0h exp bffffffff", out_data); end
        tests++; if (dct_count !== 4'd0) begin fails++; $display("FAIL bp_count_clear got %0h exp 0", dct_count); end
        tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %0h exp 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            dct_valid = 1; dct_code = (i < 15) ? 2'd1 : 2'd3;
            #1;
            tests++; if (dct_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d got %0h exp 1", i, dct_ready); end
            tick;
        end
        dct_valid = 0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'hBD5555555) begin fails++; $display("FAIL b2b_data got %0h exp bd5555555", out_data); end
        tests++; if (dct_count !== 4'd1) begin fails++; $display("FAIL b2b_count got %0h exp 1", dct_count); end
        tests++; if (dct_buffer !== 30'h3) begin fails++; $display("FAIL b2b_buffer got %0h exp 3", dct_buffer); end
        flush_req = 1;
        tick;
        flush_req = 0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_handshake got %0h exp 0", out_valid); end
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_flush_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'h440000003) begin fails++; $display("FAIL b2b_flush_data got %0h exp 440000003", out_data); end
        tick;
    endtask

    task automatic test_drain;
        out_ready = 0;
        for (int i = 0; i < 7; i++) begin
            dct_valid = 1; dct_code = codes7[i]; test_ending = (i == 6);
            tick;
        end
        test_ending = 0;
        #1;
        tests++; if (dct_ready !== 1'b0) begin fails++; $display("FAIL drain_ready got %0h exp 0", dct_ready); end
        tests++; if (dct_count !== 4'd7) begin fails++; $display("FAIL drain_count got %0h exp 7", dct_count); end
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid got %0h exp 1", out_valid); end
        tests++; if (out_data !== 36'h5C00006C6) begin fails++; $display("FAIL drain_data got %0h exp 5c00006c6", out_data); end
        tests++; if (dct_count !== 4'd0) begin fails++; $display("FAIL drain_count_clear got %0h exp 0", dct_count); end
        repeat (4) tick;
        tests++; if (test_has_ended !== 1'b0) begin fails++; $display("FAIL drain_early_end got %0h exp 0", test_has_ended); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_hold got %0h exp 1", out_valid); end
        out_ready = 1;
        tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_taken got %0h exp 0", out_valid); end
        tests++; if (test_has_ended !== 1'b1) begin fails++; $display("FAIL drain_end got %0h exp 1", test_has_ended); end
        flush_req = 1;
        tick;
        flush_req = 0;
        repeat (3) tick;
        tests++; if (test_has_ended !== 1'b1) begin fails++; $display("FAIL done_sticky got %0h exp 1", test_has_ended); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL done_valid got %0h exp 0", out_valid); end
        tests++; if (dct_ready !== 1'b0) begin fails++; $display("FAIL done_ready got %0h exp 0", dct_ready); end
        tests++; if (stall_count !== 8'd5) begin fails++; $display("FAIL done_stall got %0h exp 5", stall_count); end
    endtask

    task automatic test_reset_midframe;
        dct_valid = 0; reset = 1;
        tick;
        reset = 0; out_ready = 0;
        for (int i = 0; i < 24; i++) begin
            dct_valid = 1; dct_code = 2'(i);
            tick;
        end
        dct_valid = 0;
        tests++; if (dct_count !== 4'd9) begin fails++; $display("FAIL mid_count got %0h exp 9", dct_count); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_valid got %0h exp 1", out_valid); end
        reset = 1;
        tick;
        reset = 0;
        tests++; if (dct_count !== 4'd0) begin fails++; $display("FAIL mid_reset_count got %0h exp 0", dct_count); end
        tests++; if (dct_buffer !== 30'h0) begin fails++; $display("FAIL mid_reset_buffer got %0h exp 0", dct_buffer); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %0h exp 0", out_valid); end
        tests++; if (out_data !== 36'h0) begin fails++; $display("FAIL mid_reset_data got %0h exp 0", out_data); end
        tests++; if (test_has_ended !== 1'b0) begin fails++; $display("FAIL mid_reset_ended got %0h exp 0", test_has_ended); end
        tests++; if (stall_count !== 8'd0) begin fails++; $display("FAIL mid_reset_stall got %0h exp 0", stall_count); end
        tests++; if (dct_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_run got %0h exp 1", dct_ready); end
    endtask

    task automatic test_stall_saturation;
        out_ready = 0;
        for (int i = 0; i < 30; i++) begin
            dct_valid = 1; dct_code = 2'd1;
            tick;
        end
        repeat (254) tick;
        tests++; if (stall_count !== 8'd254) begin fails++; $display("FAIL sat_254 got %0h exp fe", stall_count); end
        repeat (10) tick;
        tests++; if (stall_count !== 8'd255) begin fails++; $display("FAIL sat_255 got %0h exp ff", stall_count); end
        dct_valid = 0;
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_flush;
        test_backpressure;
        test_back_to_back;
        test_drain;
        test_reset_midframe;
        test_stall_saturation;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
